// File: rtl/cavlc_coef_block_buffer.sv
// cavlc_coef_block_buffer
// Collects serial quantized residual coefficients into 4x4 blocks held in a
// two-bank (ping-pong) register buffer. Each completed block is presented in
// parallel to the CAVLC stages over a block-level valid/ready handshake.
// While one bank is being presented, the other bank keeps filling.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   coef_in    incoming coefficient (two's complement, stored bit-exact)
//   coef_sop   first coefficient of a block, qualified by coef_valid
//   coef_valid coef_in valid
//   coef_ready buffer can accept coef_in this cycle
//   blk_out    parallel block, element (r,c) at [(4r+c)*COEF_W +: COEF_W]
//   blk_valid  blk_out holds a complete block
//   blk_ready  consumer accepts the block
//   sop_err    one-cycle pulse: a partial block was discarded by coef_sop
//
// Build option:
//   CAVLC_ZIGZAG_IN_EN  input arrives in zigzag scan order and is scattered
//                       to raster positions; undefined = raster-order input.

module cavlc_coef_block_buffer #(
    parameter int COEF_W   = 15,
    parameter int NUM_COEF = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COEF_W-1:0]          coef_in,
    input  logic                       coef_sop,
    input  logic                       coef_valid,
    output logic                       coef_ready,
    output logic [NUM_COEF*COEF_W-1:0] blk_out,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic                       sop_err
);

    localparam int BLK_W = NUM_COEF * COEF_W;

    logic [BLK_W-1:0] bank_q [2];
    logic [1:0]       full_q;
    logic             wr_bank_q;
    logic             rd_bank_q;
    logic [3:0]       wr_cnt_q;
    logic             sop_err_q;

    logic             accept;
    logic             restart;
    logic             complete;
    logic             drain;
    logic [3:0]       wr_idx;
    logic [3:0]       slot;

    // Scan position -> raster position inside the 4x4 block.
    function automatic logic [3:0] raster_idx(input logic [3:0] k);
`ifdef CAVLC_ZIGZAG_IN_EN
        logic [3:0] r;
        r = k;
        case (k)
            4'd0:  r = 4'd0;
            4'd1:  r = 4'd1;
            4'd2:  r = 4'd4;
            4'd3:  r = 4'd8;
            4'd4:  r = 4'd5;
            4'd5:  r = 4'd2;
            4'd6:  r = 4'd3;
            4'd7:  r = 4'd6;
            4'd8:  r = 4'd9;
            4'd9:  r = 4'd12;
            4'd10: r = 4'd13;
            4'd11: r = 4'd10;
            4'd12: r = 4'd7;
            4'd13: r = 4'd11;
            4'd14: r = 4'd14;
            4'd15: r = 4'd15;
            default: r = k;
        endcase
        return r;
`else
        return k;
`endif
    endfunction

    assign coef_ready = !full_q[wr_bank_q];
    assign blk_valid  = full_q[rd_bank_q];
    assign blk_out    = bank_q[rd_bank_q];
    assign sop_err    = sop_err_q;

    always_comb begin
        accept   = coef_valid && coef_ready;
        // A start-of-block marker in the middle of a block throws away the
        // partial contents and restarts the fill at element 0.
        restart  = accept && coef_sop && (wr_cnt_q != 4'd0);
        wr_idx   = coef_sop ? 4'd0 : wr_cnt_q;
        slot     = raster_idx(wr_idx);
        complete = accept && (wr_idx == 4'd15);
        drain    = blk_valid && blk_ready;
    end

    // Completion and drain can never target the same bank in one cycle:
    // completion needs full[wr_bank]=0, drain needs full[rd_bank]=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 4'd0;
            sop_err_q <= 1'b0;
        end else begin
            sop_err_q <= restart;
            if (accept) begin
                bank_q[wr_bank_q][slot*COEF_W +: COEF_W] <= coef_in;
                wr_cnt_q <= 4'(wr_idx + 4'd1);
            end
            if (complete) begin
                full_q[wr_bank_q] <= 1'b1;
                wr_bank_q         <= ~wr_bank_q;
            end
            if (drain) begin
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= ~rd_bank_q;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_coef_block_buffer.sv
module tb_cavlc_coef_block_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [14:0]  coef_in = '0;
    logic         coef_sop = 1'b0;
    logic         coef_valid = 1'b0;
    logic         coef_ready;
    logic [239:0] blk_out;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         sop_err;

    always #5 clk = ~clk;

    cavlc_coef_block_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .coef_in    (coef_in),
        .coef_sop   (coef_sop),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .blk_out    (blk_out),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .sop_err    (sop_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of completed blocks awaiting drain, a partial
    // block under assembly, and the pending sop_err pulse.
    logic [239:0] q[$];
    logic [239:0] part = '0;
    int           cnt = 0;
    logic         exp_sop = 1'b0;
    bit           armed = 0;

    int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    function automatic int rmap(int k);
`ifdef CAVLC_ZIGZAG_IN_EN
        return zz[k];
`else
        return k;
`endif
    endfunction

    function automatic logic [14:0] elem(logic [239:0] b, int r, int c);
        return b[(4*r+c)*15 +: 15];
    endfunction

    task automatic chk(string name, logic [239:0] act, logic [239:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: compare DUT against model, apply inputs, advance model.
    task automatic cyc(logic v, logic s, logic [14:0] d, logic br, logic r);
        logic acc, drn;
        if (armed) begin
            chk("coef_ready", 240'(coef_ready), 240'(q.size() < 2));
            chk("blk_valid", 240'(blk_valid), 240'(q.size() > 0));
            chk("sop_err", 240'(sop_err), 240'(exp_sop));
            if (q.size() > 0) chk("blk_out", blk_out, q[0]);
        end
        rst = r; coef_valid = v; coef_sop = s; coef_in = d; blk_ready = br;
        if (r) begin
            q.delete();
            cnt = 0;
            exp_sop = 1'b0;
            armed = 1;
        end else begin
            acc = v && (q.size() < 2);
            drn = br && (q.size() > 0);
            exp_sop = acc && s && (cnt != 0);
            if (drn) void'(q.pop_front());
            if (acc) begin
                if (s) cnt = 0;
                part[rmap(cnt)*15 +: 15] = d;
                cnt++;
                if (cnt == 16) begin
                    q.push_back(part);
                    cnt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 15'd0, 1'b0, 1'b1);
    endtask

    initial begin : main
        int exp_t1[16];
        int idx;
        bit seen32;
        logic lv, ls, lr;
        logic [14:0] ld;

        do_reset();
        chk("rst_ready", 240'(coef_ready), 240'(1));
        chk("rst_valid", 240'(blk_valid), 240'(0));
        chk("rst_blk_out", blk_out, 240'(0));

        // Test 1: one block streamed with the consumer always ready.
`ifdef CAVLC_ZIGZAG_IN_EN
        exp_t1 = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};
        for (int i = 0; i < 16; i++) cyc(1'b1, i == 0, 15'(i), 1'b1, 1'b0);
`else
        for (int i = 0; i < 16; i++) exp_t1[i] = i + 1;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 15'(i + 1), 1'b1, 1'b0);
`endif
        chk("t1_valid_rise", 240'(blk_valid), 240'(1));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk("t1_elem", 240'(elem(blk_out, r, c)), 240'(exp_t1[4*r+c]));
        cyc(1'b0, 1'b0, 15'd0, 1'b1, 1'b0);
        chk("t1_valid_fall", 240'(blk_valid), 240'(0));

        // Test 2: three back-to-back blocks, consumer stalled until cycle 40.
        idx = 0;
        seen32 = 0;
        for (int n = 0; n < 200 && idx < 48; n++) begin
            logic rdy;
            rdy = q.size() < 2;
            cyc(1'b1, 1'b0, 15'(100 * (idx / 16 + 1) + idx % 16), n >= 40, 1'b0);
            if (rdy) idx++;
            if (idx == 32 && !seen32) begin
                seen32 = 1;
                chk("t2_full_ready", 240'(coef_ready), 240'(0));
                chk("t2_first_blk", 240'(elem(blk_out, 0, 0)), 240'(100));
            end
        end
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 15'd0, 1'b1, 1'b0);

        // Test 3: coef_sop in the middle of a block discards the partial.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 15'(50 + i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 15'h7fff, 1'b0, 1'b0);
        chk("t3_sop_err", 240'(sop_err), 240'(1));
        cyc(1'b1, 1'b0, 15'd500, 1'b0, 1'b0);
        chk("t3_sop_err_pulse", 240'(sop_err), 240'(0));
        for (int i = 1; i < 15; i++) cyc(1'b1, 1'b0, 15'(500 + i), 1'b0, 1'b0);
        chk("t3_elem00", 240'(elem(blk_out, 0, 0)), 240'(15'h7fff));
        chk("t3_elem01", 240'(elem(blk_out, 0, 1)), 240'(500));
        cyc(1'b0, 1'b0, 15'd0, 1'b1, 1'b0);

        // Test 4: drain of bank 0 coincides with the 16th accept into bank 1.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 15'(600 + i), 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 15'(700 + i), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 15'(715), 1'b1, 1'b0);
        chk("t4_valid", 240'(blk_valid), 240'(1));
        chk("t4_ready", 240'(coef_ready), 240'(1));
        chk("t4_bank1", 240'(elem(blk_out, 0, 0)), 240'(700));
        cyc(1'b0, 1'b0, 15'd0, 1'b1, 1'b0);

        // Test 5: reset with a full bank pending and a partial block.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 15'(800 + i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 15'(900 + i), 1'b0, 1'b0);
        do_reset();
        chk("t5_valid", 240'(blk_valid), 240'(0));
        chk("t5_ready", 240'(coef_ready), 240'(1));
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 15'(1000 + i), 1'b0, 1'b0);
        chk("t5_elem00", 240'(elem(blk_out, 0, 0)), 240'(1000));
        chk("t5_elem33", 240'(elem(blk_out, 3, 3)), 240'(rmap(15) == 15 ? 1015 : 0));
        cyc(1'b0, 1'b0, 15'd0, 1'b1, 1'b0);

        // Randomized traffic; held inputs while stalled.
        lv = 0; ls = 0; ld = '0; lr = 1;
        for (int n = 0; n < 4000; n++) begin
            logic v, s, br, r;
            logic [14:0] d;
            logic rdy;
            rdy = q.size() < 2;
            if (lv && !lr) begin
                v = 1'b1; s = ls; d = ld;
            end else begin
                v = $urandom_range(0, 9) < 8;
                s = $urandom_range(0, 19) == 0;
                d = 15'($urandom);
            end
            br = $urandom_range(0, 9) < 6;
            r  = $urandom_range(0, 599) == 0;
            cyc(v, s, d, br, r);
            lv = v && !r; ls = s; ld = d; lr = rdy;
        end
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 15'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
